uart_rx: RTL

Receives 8N1 asynchronous serial frames on the FPGA UART RX pin and presents each byte on a valid/ready interface. This is the first stage of the UART-to-ALU datapath. It shares its counting style with the other timer blocks in the design: a free-running `bsg_counter_up_down` cleared at a terminal count. Downstream, the command parser consumes its bytes.

---
 rtl/uart_pkg.sv | 16 +
 rtl/bsg_counter_up_down.sv | 24 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 138 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path and the future transmitter.
package uart_pkg;

   localparam int DataWidth         = 8;
   localparam int DefaultClksPerBit = 868;

   typedef logic [DataWidth-1:0] uart_byte_t;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_e;

endpackage

// File: rtl/bsg_counter_up_down.sv
// Up/down counter with synchronous clear; callers keep the count within max_val_p.
module bsg_counter_up_down #(
   parameter  int max_val_p     = 16,
   parameter  int init_val_p    = 0,
   parameter  int max_step_p    = 1,
   localparam int step_width_lp = $clog2(max_step_p + 1),
   localparam int ptr_width_lp  = $clog2(max_val_p + 1)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [step_width_lp-1:0] up_i,
   input  logic [step_width_lp-1:0] down_i,
   output logic [ptr_width_lp-1:0]  count_o
);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_o <= ptr_width_lp'(init_val_p);
      end else begin
         count_o <= count_o + ptr_width_lp'(up_i) - ptr_width_lp'(down_i);
      end
   end

endmodule

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
module sync_2ff #(
   parameter logic ResetVal = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= ResetVal;
         q_o    <= ResetVal;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer.
//
// state | meaning
// IDLE  | line idle, bit counter held clear, waiting for rx_s low
// START | counting to the start-bit mid-point, rejecting glitches
// DATA  | sampling eight data bits LSB first, one per bit period
// STOP  | sampling the stop bit, then delivering or flagging the byte
module uart_rx
   import uart_pkg::*;
#(
   parameter int ClksPerBit = DefaultClksPerBit
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       rx_i,
   output uart_byte_t data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o
);

   localparam int HalfBit    = ClksPerBit / 2;
   localparam int CountWidth = $clog2(ClksPerBit);
   localparam int CntBits    = $clog2(ClksPerBit + 1);

   logic                  rx_s;
   rx_state_e             state_q, state_d;
   logic [2:0]            bit_idx_q, bit_idx_d;
   uart_byte_t            shift_q, shift_d;
   logic [CntBits-1:0]    cnt;
   logic [CountWidth-1:0] tick;
   logic                  sample;
   logic                  cnt_clr;
   logic                  deliver;
   logic                  stop_bad;

   sync_2ff #(
      .ResetVal (1'b1)
   ) u_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (rx_i),
      .q_o     (rx_s)
   );

   bsg_counter_up_down #(
      .max_val_p  (ClksPerBit),
      .init_val_p (0),
      .max_step_p (1)
   ) u_bit_cnt (
      .clk_i   (clk_i),
      .reset_i (cnt_clr),
      .up_i    (1'b1),
      .down_i  (1'b0),
      .count_o (cnt)
   );

   // The count is cleared at every sample, so it never exceeds ClksPerBit-1.
   assign tick    = CountWidth'(cnt);
   assign cnt_clr = reset_i || (state_q == IDLE) || sample;

   always_comb begin
      sample = 1'b0;
      case (state_q)
         START:      sample = (tick == CountWidth'(HalfBit));
         DATA, STOP: sample = (tick == CountWidth'(ClksPerBit - 1));
         default:    sample = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         bit_idx_q <= 3'd0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      deliver   = 1'b0;
      stop_bad  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) state_d = START;
         end
         START: begin
            if (sample) state_d = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (sample) begin
               shift_d[bit_idx_q] = rx_s;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (sample) begin
               deliver  = rx_s;
               stop_bad = !rx_s;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A delivery coinciding with acceptance refills the buffer instead of overrunning.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         data_o      <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         frame_err_o <= stop_bad;
         overrun_o   <= 1'b0;
         if (deliver) begin
            if (!valid_o || ready_i) begin
               data_o  <= shift_q;
               valid_o <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end else if (ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule
